// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV/MOD engine beside the execute-stage ALU.
// Shift-add multiply and restoring divide, one bit per clock, sequenced by a small FSM.
module muldiv_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             done,
    output logic             busy,
    output logic             stall,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_MOD = 2'b10;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 overflow_q, overflow_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;

    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       divShift;
    logic                 divFits;
    logic [WIDTH:0]       remNext;
    logic [WIDTH-1:0]     quoNext;
    logic                 opLegal;
    logic [WIDTH-1:0]     degResult;
    logic [WIDTH-1:0]     finResult;
    logic [WIDTH-1:0]     finHi;

    // opnd_q holds the multiplicand for MUL and the divisor for DIV/MOD.
    assign mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mulNext  = {mulSum, prod_q[WIDTH-1:1]};
    assign divShift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, opnd_q};
    assign remNext  = divFits ? (divShift - {1'b0, opnd_q}) : divShift;
    assign quoNext  = {quo_q[WIDTH-2:0], divFits};

    assign opLegal = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (operand_b != '0));

    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);
    assign stall     = busy | (start & (state_q != BUSY) & opLegal);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign err       = err_q;

    always_comb begin
        degResult = '0;
        case (op)
            OP_DIV:  degResult = '1;
            OP_MOD:  degResult = operand_a;
            default: degResult = '0;
        endcase
        finResult = '0;
        finHi     = '0;
        case (op_q)
            OP_MUL: begin
                finResult = mulNext[WIDTH-1:0];
                finHi     = mulNext[2*WIDTH-1:WIDTH];
            end
            OP_DIV:  finResult = quoNext;
            default: finResult = remNext[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        err_d       = err_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d       = op;
                    overflow_d = 1'b0;
                    zero_d     = 1'b0;
                    err_d      = 1'b0;
                    if (opLegal) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        if (op == OP_MUL) begin
                            opnd_d = operand_a;
                            prod_d = {{WIDTH{1'b0}}, operand_b};
                        end else begin
                            opnd_d = operand_b;
                            rem_d  = '0;
                            quo_d  = operand_a;
                        end
                    end else begin
                        // Divide by zero or illegal op completes at once with err set.
                        state_d     = DONE;
                        result_d    = degResult;
                        result_hi_d = '0;
                        err_d       = 1'b1;
                        zero_d      = (degResult == '0);
                    end
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    prod_d = mulNext;
                end else begin
                    rem_d = remNext;
                    quo_d = quoNext;
                end
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    result_d    = finResult;
                    result_hi_d = finHi;
                    overflow_d  = (op_q == OP_MUL) && (finHi != '0);
                    zero_d      = (finResult == '0) && (finHi == '0);
                    err_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer, checked against a plain-arithmetic model.
module tb_muldiv_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         done;
    logic         busy;
    logic         stall;
    logic         overflow;
    logic         zero;
    logic         err;

    int errCount   = 0;
    int checkCount = 0;

    logic [W-1:0] expR;
    logic [W-1:0] expHi;
    logic         expOv;
    logic         expZero;
    logic         expErr;
    logic         expLegal;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .result_hi (result_hi),
        .done      (done),
        .busy      (busy),
        .stall     (stall),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain arithmetic on the operands, no notion of cycles.
    task automatic computeModel(input logic [1:0] opIn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        p       = longint'(a) * longint'(b);
        expHi   = '0;
        expOv   = 1'b0;
        expErr  = 1'b0;
        expLegal = 1'b1;
        case (opIn)
            2'b00: begin
                expR  = p[W-1:0];
                expHi = p[2*W-1:W];
                expOv = (expHi != 0);
            end
            2'b01: begin
                if (b == 0) begin expR = '1; expErr = 1'b1; expLegal = 1'b0; end
                else expR = a / b;
            end
            2'b10: begin
                if (b == 0) begin expR = a; expErr = 1'b1; expLegal = 1'b0; end
                else expR = a % b;
            end
            default: begin
                expR = '0; expErr = 1'b1; expLegal = 1'b0;
            end
        endcase
        expZero = (expR == 0) && (expHi == 0);
    endtask

    // Caller sits at a falling edge with the engine in IDLE or DONE; returns at the falling edge where done is seen.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [W-1:0] a, input logic [W-1:0] b, input int intrudeAt);
        int k;
        int busyBad;
        computeModel(opIn, a, b);
        op        = opIn;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        #1;
        checkOutput("stall_on_start", stall, expLegal);
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        k       = 0;
        busyBad = 0;
        while (!done && k < W + 8) begin
            if (busy !== expLegal || stall !== busy) busyBad++;
            if (k == intrudeAt) begin
                start     = 1'b1;
                op        = 2'b01;
                operand_a = 9;
                operand_b = 3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checkOutput("latency", k, expLegal ? W : 0);
        checkOutput("done", done, 1);
        checkOutput("busy_with_done", busy, 0);
        checkOutput("busy_profile", busyBad, 0);
        checkOutput("result", result, expR);
        checkOutput("result_hi", result_hi, expHi);
        checkOutput("overflow", overflow, expOv);
        checkOutput("zero", zero, expZero);
        checkOutput("err", err, expErr);
    endtask

    task automatic idleCheck(input int cycles);
        int dones;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("no_extra_done", dones, 0);
        checkOutput("result_hold", {result_hi, result, overflow, zero, err}, {expHi, expR, expOv, expZero, expErr});
    endtask

    initial begin
        int dones;
        logic [1:0]   rOp;
        logic [W-1:0] rA;
        logic [W-1:0] rB;
        rst       = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        #12;
        checkOutput("reset_outputs", {result, result_hi, done, busy, stall, overflow, zero, err}, '0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(2'b00, 300, 250, -1);
        checkOutput("mul_const_lo", result, 9464);
        idleCheck(2);
        applyStimulus(2'b01, 1000, 7, -1);
        checkOutput("div_const", result, 142);
        idleCheck(1);
        applyStimulus(2'b10, 1000, 7, -1);
        checkOutput("mod_const", result, 6);
        idleCheck(1);
        applyStimulus(2'b01, 5, 0, -1);
        checkOutput("div0_const", result, 16'hFFFF);
        idleCheck(1);
        applyStimulus(2'b10, 5, 0, -1);
        idleCheck(1);
        applyStimulus(2'b11, 5, 9, -1);
        idleCheck(1);

        applyStimulus(2'b00, 3, 4, 4);
        idleCheck(W + 4);

        applyStimulus(2'b00, 1234, 77, -1);
        applyStimulus(2'b00, 0, 77, -1);
        idleCheck(2);

        for (int n = 0; n < 30; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = W'($urandom);
            rB  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            applyStimulus(rOp, rA, rB, -1);
            if ($urandom_range(0, 3) != 0) idleCheck($urandom_range(1, 3));
        end
        idleCheck(1);

        applyStimulus(2'b00, 300, 250, -1);
        idleCheck(1);
        op        = 2'b01;
        operand_a = 1000;
        operand_b = 7;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {result, result_hi, done, busy, stall, overflow, zero, err}, '0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checkOutput("no_done_after_reset", dones, 0);
        applyStimulus(2'b01, 20, 4, -1);
        checkOutput("div_after_reset", result, 5);
        idleCheck(2);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide/modulo engine, sequenced by its own FSM.
- Sits beside the single-cycle ALU in the execute stage.
- The control unit issues a one-cycle start and holds the pipeline on `stall` until `done`.
- Frees the combinational ALU from MUL/DIV/MOD; uses iterative shift-add multiply and restoring divide, one bit per clock.

Parameters:
- WIDTH, 16: operand and result width in bits; legal values are 4 to 32.
- CNT_W, 5: width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- start  input  1  one-cycle request; sampled on the rising edge of clk.
- op  input  2  operation: 00 = MUL, 01 = DIV, 10 = MOD, 11 = illegal.
- operand_a  input  WIDTH  multiplicand or dividend; sampled with start.
- operand_b  input  WIDTH  multiplier or divisor; sampled with start.
- result  output  WIDTH  MUL low half, DIV quotient, or MOD remainder.
- result_hi  output  WIDTH  MUL high half; 0 for DIV and MOD.
- done  output  1  one-cycle pulse marking result valid.
- busy  output  1  high while iterating.
- stall  output  1  combinational `busy | (start & state==IDLE/DONE & legal, nonzero-divisor op)`; the control unit freezes PC and IF/ID on this.
- overflow  output  1  MUL only: result_hi != 0.
- zero  output  1  result == 0 (and result_hi == 0 for MUL).
- err  output  1  divide by zero, or op == 11.

Behaviour:
- Reset (rst = 0, any time, including mid-operation):
  - state goes to IDLE immediately.
  - result, result_hi, done, busy, overflow, zero and err all go to 0.
  - Iteration registers are cleared.
- States: IDLE, BUSY, DONE.
- In IDLE or DONE with start = 1:
  - Latch op and both operands, and clear the flags.
  - Legal case (MUL, or DIV/MOD with operand_b != 0): go to BUSY, counter = WIDTH-1, busy = 1 from the next cycle.
  - Degenerate case (operand_b == 0 for DIV/MOD, or op == 11): go straight to DONE with no BUSY cycles. stall stays 0.
- In IDLE or DONE with start = 0:
  - DONE always returns to IDLE after one cycle.
  - result and the flags hold their values until the next accepted start.
- BUSY:
  - One iteration per clock.
  - When counter == 0, go to DONE and clear busy.
  - If counter != 0, decrement it.
  - start is ignored while BUSY; no queuing, and the operands are not re-sampled.
- MUL:
  - 2*WIDTH-bit product built by shift-add over the multiplier bits, LSB first.
  - After the final iteration: result = product[WIDTH-1:0], result_hi = product[2*WIDTH-1:WIDTH].
- DIV/MOD:
  - Restoring division: the partial remainder is WIDTH+1 bits, the quotient is shifted in MSB first.
  - result is the quotient (DIV) or the remainder (MOD); result_hi = 0.
- Latency:
  - Start accepted at edge E0 means busy is high for cycles E0..E_WIDTH.
  - done is high for exactly one cycle after E_WIDTH.
  - Degenerate case: done is high for the cycle after E0.
- done:
  - Registered, exactly one cycle long, never high while busy.
  - A back-to-back start in the DONE cycle is accepted; done then drops and busy rises on the next edge.
- Degenerate results (all with err = 1, overflow = 0):
  - DIV by 0: result = all ones.
  - MOD by 0: result = operand_a.
  - op 11: result = 0.
- Flags update together with result at the DONE transition. zero is computed from the final values.

Test Plan:
- MUL, WIDTH=16: start with op=00, a=300, b=250 → done exactly 16 cycles after the start edge, result=9464, result_hi=1, overflow=1, zero=0, err=0; stall high from the start cycle through the last BUSY cycle.
- DIV/MOD: a=1000, b=7 → op=01 gives result=142, result_hi=0; op=10 gives result=6; err=0 and 16-cycle latency in both cases.
- Degenerate: DIV 5/0 → done 1 cycle after start, result=16'hFFFF, err=1, busy never high. MOD 5/0 → result=5, err=1. op=11 → result=0, zero=1, err=1.
- Start ignored while busy: MUL 3*4 started; on cycle 5, pulse start with DIV 9/3 → single done, result=12, result_hi=0, zero=0; no second done.
- Back-to-back: start MUL 0*77 in the DONE cycle of the previous op → done pulses twice, 16 cycles apart; second result=0, zero=1, overflow=0.
- Reset mid-operation: assert rst=0 at cycle 8 of DIV 1000/7, asynchronous and between edges → outputs go to 0 immediately with no done. After release, DIV 20/4 gives result=5 after 16 cycles.
